serial_prefix_add_ctrl: RTL and testbench

SERIAL_PREFIX_ADD_CTRL -- requirements
Module: serial_prefix_add_ctrl

---
 rtl/serial_prefix_add_ctrl.sv | 103 ++++++++++
 tb/tb_serial_prefix_add_ctrl.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/serial_prefix_add_ctrl.sv
// 33-bit add {cout,sum} = a + b + cin through one 8-bit slice over four beats; optional ovf via SERIAL_ADD_OVF_EN.
// Latency 4 cycles accept->out_valid; result holds in DONE until out_ready, flush aborts at the next edge.
module serial_prefix_add_ctrl (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        flush,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        cin,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] sum,
    output logic        cout,
    output logic        busy
`ifdef SERIAL_ADD_OVF_EN
   ,output logic        ovf
`endif
);

    typedef enum logic [1:0] {IDLE, ADD, DONE} state_t;

    state_t      state;
    logic [31:0] a_q;
    logic [31:0] b_q;
    logic        carry_q;
    logic [1:0]  k;
    logic [8:0]  slice;

    // The shared slice adder: byte k of both operands plus the running carry.
    always_comb begin
        slice = {1'b0, a_q[{k, 3'b000} +: 8]} + {1'b0, b_q[{k, 3'b000} +: 8]} + {8'd0, carry_q};
    end

    assign in_ready = (state == IDLE);
    assign busy     = (state != IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            a_q       <= '0;
            b_q       <= '0;
            carry_q   <= 1'b0;
            k         <= 2'd0;
            sum       <= '0;
            cout      <= 1'b0;
            out_valid <= 1'b0;
`ifdef SERIAL_ADD_OVF_EN
            ovf       <= 1'b0;
`endif
        end else if (flush) begin
            state     <= IDLE;
            carry_q   <= 1'b0;
            k         <= 2'd0;
            sum       <= '0;
            cout      <= 1'b0;
            out_valid <= 1'b0;
`ifdef SERIAL_ADD_OVF_EN
            ovf       <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_q     <= a;
                        b_q     <= b;
                        carry_q <= cin;
                        k       <= 2'd0;
                        sum     <= '0;
                        cout    <= 1'b0;
`ifdef SERIAL_ADD_OVF_EN
                        ovf     <= 1'b0;
`endif
                        state   <= ADD;
                    end
                end
                ADD: begin
                    sum[{k, 3'b000} +: 8] <= slice[7:0];
                    carry_q <= slice[8];
                    k       <= k + 2'd1;
                    if (k == 2'd3) begin
                        state     <= DONE;
                        out_valid <= 1'b1;
                        cout      <= slice[8];
`ifdef SERIAL_ADD_OVF_EN
                        // slice[7] is the sum MSB being written on this beat.
                        ovf       <= (a_q[31] == b_q[31]) && (slice[7] != a_q[31]);
`endif
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state     <= IDLE;
                        out_valid <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_serial_prefix_add_ctrl.sv
// Scoreboard bench for serial_prefix_add_ctrl: expected {ovf,cout,sum} queued at accept, compared on out_valid.
module tb_serial_prefix_add_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] a = '0;
    logic [31:0] b = '0;
    logic        cin = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] sum;
    logic        cout;
    logic        busy;
`ifdef SERIAL_ADD_OVF_EN
    logic        ovf;
`endif

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int acc_cyc = 0;
    logic [33:0] sb[$];

    serial_prefix_add_ctrl dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .cin(cin),
        .out_valid(out_valid), .out_ready(out_ready),
        .sum(sum), .cout(cout), .busy(busy)
`ifdef SERIAL_ADD_OVF_EN
       ,.ovf(ovf)
`endif
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [33:0] model(input logic [31:0] x, input logic [31:0] y, input logic c);
        logic [32:0] r;
        logic        v;
        r = {1'b0, x} + {1'b0, y} + {32'd0, c};
        v = (x[31] == y[31]) && (r[31] != x[31]);
        return {v, r};
    endfunction

    // Called at posedge+1; presents one request, pushes its expectation, returns just after the accept edge.
    task automatic drive_accept(input logic [31:0] x, input logic [31:0] y, input logic c);
        a = x; b = y; cin = c; in_valid = 1'b1;
        sb.push_back(model(x, y, c));
        @(posedge clk); #1;
        in_valid = 1'b0;
        acc_cyc = cyc;
    endtask

    task automatic wait_out(output int lat);
        int n;
        n = 0;
        lat = -1;
        while (n < 20 && !out_valid) begin
            @(posedge clk); #1;
            n++;
        end
        if (out_valid) lat = cyc - acc_cyc;
    endtask

    task automatic check_result(input string name);
        logic [33:0] e;
        int lat;
        wait_out(lat);
        e = (sb.size() > 0) ? sb.pop_front() : 34'h0;
        checks++;
        if (lat !== 4) begin errors++; $display("FAIL %s latency got %0d want 4", name, lat); end
        checks++;
        if ({cout, sum} !== e[32:0]) begin errors++; $display("FAIL %s result got %h_%h want %h", name, cout, sum, e[32:0]); end
`ifdef SERIAL_ADD_OVF_EN
        checks++;
        if (ovf !== e[33]) begin errors++; $display("FAIL %s ovf got %b want %b", name, ovf, e[33]); end
`endif
    endtask

    task automatic test_reset;
        #1;
        checks++;
        if ({out_valid, busy, cout, sum} !== 35'd0) begin errors++; $display("FAIL reset_outputs got ov=%b busy=%b cout=%b sum=%h want 0", out_valid, busy, cout, sum); end
        @(negedge clk); rst_n = 1'b1;
        repeat (2) @(posedge clk); #1;
        checks++;
        if (busy !== 1'b0 || in_ready !== 1'b1 || out_valid !== 1'b0) begin errors++; $display("FAIL reset_release got busy=%b rdy=%b ov=%b want 0 1 0", busy, in_ready, out_valid); end
    endtask

    task automatic test_carry_cross;
        out_ready = 1'b1;
        drive_accept(32'h0000_00FF, 32'h0000_0001, 1'b0);
        check_result("carry_cross");
        checks++;
        if (in_ready !== 1'b0) begin errors++; $display("FAIL done_in_ready got %b want 0", in_ready); end
        @(posedge clk); #1;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin errors++; $display("FAIL handshake_idle got ov=%b rdy=%b want 0 1", out_valid, in_ready); end
    endtask

    task automatic test_wrap;
        drive_accept(32'hFFFF_FFFF, 32'h0000_0000, 1'b1);
        check_result("wrap");
        @(posedge clk); #1;
    endtask

    task automatic test_hold;
        logic [32:0] held;
        out_ready = 1'b0;
        drive_accept(32'h7FFF_FFFF, 32'h0000_0001, 1'b0);
        check_result("hold");
        held = {cout, sum};
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            checks++;
            if (out_valid !== 1'b1 || in_ready !== 1'b0 || {cout, sum} !== held) begin
                errors++; $display("FAIL hold_stable cycle %0d got ov=%b rdy=%b res=%h want 1 0 %h", i, out_valid, in_ready, {cout, sum}, held);
            end
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (out_valid !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL hold_release got ov=%b busy=%b want 0 0", out_valid, busy); end
    endtask

    task automatic test_flush;
        drive_accept(32'h1234_5678, 32'h1111_1111, 1'b0);
        @(posedge clk); #1;
        checks++;
        if (sum !== 32'h0000_0089) begin errors++; $display("FAIL partial_beat0 got %h want 00000089", sum); end
        @(posedge clk); #1;
        checks++;
        if (sum !== 32'h0000_6789) begin errors++; $display("FAIL partial_beat1 got %h want 00006789", sum); end
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        void'(sb.pop_back());
        checks++;
        if (in_ready !== 1'b1 || busy !== 1'b0 || sum !== 32'd0 || out_valid !== 1'b0) begin
            errors++; $display("FAIL flush_idle got rdy=%b busy=%b sum=%h ov=%b want 1 0 0 0", in_ready, busy, sum, out_valid);
        end
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            checks++;
            if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_no_out cycle %0d got %b want 0", i, out_valid); end
        end
        // Flush wins over a simultaneous accept.
        flush = 1'b1; in_valid = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0; in_valid = 1'b0;
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL flush_vs_accept got busy=%b want 0", busy); end
        drive_accept(32'd1, 32'd2, 1'b0);
        check_result("after_flush");
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid;
        drive_accept(32'h0101_0101, 32'h0101_0101, 1'b0);
        @(posedge clk); #1;
        checks++;
        if (sum !== 32'h0000_0002) begin errors++; $display("FAIL mid_partial got %h want 00000002", sum); end
        rst_n = 1'b0;
        #1;
        void'(sb.pop_back());
        checks++;
        if ({out_valid, busy, cout, sum} !== 35'd0) begin errors++; $display("FAIL async_reset got ov=%b busy=%b cout=%b sum=%h want 0", out_valid, busy, cout, sum); end
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (in_ready !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL post_reset got rdy=%b busy=%b want 1 0", in_ready, busy); end
        drive_accept(32'h0101_0101, 32'h0202_0202, 1'b0);
        check_result("post_reset_add");
        @(posedge clk); #1;
    endtask

    task automatic test_back_to_back;
        int n_acc, n_out, prev_acc, budget;
        logic [33:0] e;
        logic [31:0] x, y;
        logic        c;
        n_acc = 0; n_out = 0; prev_acc = -1; budget = 0;
        out_ready = 1'b1;
        in_valid = 1'b1;
        while ((n_acc < 1000 || n_out < 1000) && budget < 7000) begin
            if (out_valid) begin
                e = (sb.size() > 0) ? sb.pop_front() : 34'h0;
                checks++;
                if ({cout, sum} !== e[32:0] || (cyc - acc_cyc) !== 4) begin
                    errors++; $display("FAIL b2b_result #%0d got %h lat %0d want %h lat 4", n_out, {cout, sum}, cyc - acc_cyc, e[32:0]);
                end
                n_out++;
            end
            if (in_ready && n_acc < 1000) begin
                x = $urandom; y = $urandom; c = 1'($urandom_range(0, 1));
                a = x; b = y; cin = c;
                sb.push_back(model(x, y, c));
                acc_cyc = cyc + 1;
                if (prev_acc >= 0) begin
                    checks++;
                    if (acc_cyc - prev_acc !== 6) begin errors++; $display("FAIL b2b_spacing #%0d got %0d want 6", n_acc, acc_cyc - prev_acc); end
                end
                prev_acc = acc_cyc;
                n_acc++;
                if (n_acc == 1000) begin
                    @(posedge clk); #1;
                    in_valid = 1'b0;
                    budget++;
                    continue;
                end
            end
            @(posedge clk); #1;
            budget++;
        end
        in_valid = 1'b0;
        checks++;
        if (n_out !== 1000) begin errors++; $display("FAIL b2b_count got %0d want 1000", n_out); end
    endtask

    initial begin
        test_reset;
        test_carry_cross;
        test_wrap;
        test_hold;
        test_flush;
        test_reset_mid;
        test_back_to_back;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
